// File: rtl/snn_pkg.sv
// Shared defaults, FSM state type and index-width helper for the spiking-neuron scheduler.
package snn_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 8;
    localparam int W_DEF     = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        ACC  = 3'd2,
        LEAK = 3'd3,
        DONE = 3'd4
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_vmem_rf.sv
// Membrane register file: one combinational read port, one write port, synchronous clear.
module snn_vmem_rf
    import snn_pkg::*;
#(
    parameter int DEPTH = N_OUT_DEF,
    parameter int W     = W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [idx_w(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]            wr_data,
    input  logic [idx_w(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]            rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Clear has priority over a coincident write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neuron_sched.sv
// Time-multiplexes N_OUT neurons onto one external combinational neuron datapath,
// scanning the latched input spikes and fetching one weight per active input.
//
// state | meaning
// IDLE  | waiting for start; clear_vmem honoured here
// SCAN  | test latched spike[i]; issue weight read if set
// ACC   | weight arrives; accumulate into vmem[o]
// LEAK  | leak/threshold vmem[o], record spike bit o
// DONE  | one-cycle completion pulse, out_spikes updated
module neuron_sched
    import snn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int W     = W_DEF
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           start,
    input  logic                           clear_vmem,
    input  logic [N_IN-1:0]                in_spikes,
    input  logic [W-1:0]                   beta,
    input  logic [W-1:0]                   v_th,
    output logic                           w_rd_en,
    output logic [idx_w(N_IN*N_OUT)-1:0]   w_addr,
    input  logic [W-1:0]                   w_data,
    output logic [W-1:0]                   n_weight,
    output logic [W-1:0]                   n_v_mem,
    output logic [W-1:0]                   n_beta,
    output logic [W-1:0]                   n_v_th,
    output logic                           n_function_sel,
    input  logic [W-1:0]                   n_v_mem_out,
    input  logic                           n_spike,
    output logic                           busy,
    output logic                           done,
    output logic [N_OUT-1:0]               out_spikes
);

    localparam int IW = idx_w(N_IN);
    localparam int OW = idx_w(N_OUT);
    localparam int AW = idx_w(N_IN * N_OUT);

    state_t            state;
    logic [IW-1:0]     i_q;
    logic [OW-1:0]     o_q;
    logic [N_IN-1:0]   spk_q;
    logic [W-1:0]      beta_q;
    logic [W-1:0]      vth_q;
    logic [N_OUT-1:0]  acc_q;
    logic [N_OUT-1:0]  acc_nxt;
    logic [W-1:0]      vmem_rd;
    logic              last_i;
    logic              last_o;
    logic              cur_spk;
    logic              vmem_we;
    logic              vmem_clr;

    assign last_i  = (i_q == IW'(N_IN - 1));
    assign last_o  = (o_q == OW'(N_OUT - 1));
    assign cur_spk = spk_q[i_q];

    // Neuron-facing signals decode from registered state so the weight that
    // arrives one cycle after the read strobe feeds the datapath directly.
    assign w_rd_en        = (state == SCAN) && cur_spk;
    assign w_addr         = AW'(o_q) * AW'(N_IN) + AW'(i_q);
    assign n_function_sel = (state == LEAK);
    assign n_weight       = (state == ACC) ? w_data : '0;
    assign n_v_mem        = vmem_rd;
    assign n_beta         = beta_q;
    assign n_v_th         = vth_q;

    assign vmem_we  = (state == ACC) || (state == LEAK);
    assign vmem_clr = (state == IDLE) && clear_vmem;

    always_comb begin
        acc_nxt      = acc_q;
        acc_nxt[o_q] = n_spike;
    end

    snn_vmem_rf #(
        .DEPTH (N_OUT),
        .W     (W)
    ) u_vmem (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (vmem_clr),
        .we      (vmem_we),
        .wr_addr (o_q),
        .wr_data (n_v_mem_out),
        .rd_addr (o_q),
        .rd_data (vmem_rd)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            i_q        <= '0;
            o_q        <= '0;
            spk_q      <= '0;
            beta_q     <= '0;
            vth_q      <= '0;
            acc_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_spikes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        spk_q  <= in_spikes;
                        beta_q <= beta;
                        vth_q  <= v_th;
                        acc_q  <= '0;
                        o_q    <= '0;
                        i_q    <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_spk) begin
                        state <= ACC;
                    end else if (last_i) begin
                        state <= LEAK;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                ACC: begin
                    if (last_i) begin
                        state <= LEAK;
                    end else begin
                        i_q   <= i_q + 1'b1;
                        state <= SCAN;
                    end
                end
                LEAK: begin
                    acc_q <= acc_nxt;
                    if (last_o) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        out_spikes <= acc_nxt;
                        state      <= DONE;
                    end else begin
                        o_q   <= o_q + 1'b1;
                        i_q   <= '0;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 SHALL have parameters: N_IN, default 16, input spikes per time step; N_OUT, default 8, neurons time-multiplexed onto the one neuron datapath; W, default 8, weight and membrane width.
REQ-002 SHALL have ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a time step.
- clear_vmem  in  1  zeroes all stored membranes.
- in_spikes  in  N_IN  input spike vector.
- beta  in  W  leak factor.
- v_th  in  W  threshold.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  log2(N_IN*N_OUT)  weight address, o*N_IN+i.
- w_data  in  W  weight, valid 1 cycle after w_rd_en.
- n_weight  out  W  to neuron weight.
- n_v_mem  out  W  to neuron v_mem_in.
- n_beta  out  W  to neuron beta.
- n_v_th  out  W  to neuron v_th.
- n_function_sel  out  1  0 = accumulate, 1 = leak/threshold.
- n_v_mem_out  in  W  from neuron v_mem_out.
- n_spike  in  1  from neuron spike.
- busy  out  1  time step in progress.
- done  out  1  one-cycle pulse, time step complete.
- out_spikes  out  N_OUT  spike vector of the last completed step.

Function
REQ-003 SHALL treat the attached neuron as combinational: function_sel 0 gives v_mem_out = saturating v_mem_in + signed weight; function_sel 1 applies beta leak, compares with v_th, and asserts spike with reset membrane on crossing.
REQ-004 SHALL implement FSM states IDLE, SCAN, ACC, LEAK, DONE.
REQ-005 In IDLE, start SHALL latch in_spikes, beta, v_th, clear the spike accumulator, set o=0, i=0, and go to SCAN; busy is high from the next cycle.
REQ-006 In SCAN, if latched spike[i]=1 SHALL assert w_rd_en with w_addr=o*N_IN+i and go to ACC; otherwise SHALL advance i.
REQ-007 In SCAN, after i=N_IN-1 has been handled, SHALL go to LEAK.
REQ-008 In ACC, SHALL drive n_function_sel=0, n_weight=w_data, n_v_mem=vmem[o].
REQ-009 In ACC, SHALL write n_v_mem_out into vmem[o], then advance i and return to SCAN, or go to LEAK if i was N_IN-1.
REQ-010 In LEAK, SHALL drive n_function_sel=1, n_v_mem=vmem[o], write n_v_mem_out into vmem[o], and record n_spike into spike accumulator bit o.
REQ-011 From LEAK, SHALL go to SCAN with o+1, i=0 if o<N_OUT-1, else to DONE.
REQ-012 DONE SHALL last one cycle: done=1, out_spikes loaded from the spike accumulator, busy=0, next state IDLE.
REQ-013 Busy duration SHALL be exactly N_OUT*(N_IN+k+1) cycles, where k = popcount(latched in_spikes), followed by the DONE cycle.
REQ-014 n_beta and n_v_th SHALL always equal the latched values.
REQ-015 In states other than ACC, n_weight SHALL be 0.
REQ-016 start while busy or in DONE SHALL be ignored; in_spikes changes mid-step SHALL have no effect.
REQ-017 clear_vmem in IDLE SHALL zero all vmem entries the next cycle.
REQ-018 clear_vmem while busy SHALL be ignored.
REQ-019 If clear_vmem and start coincide in IDLE, clear SHALL take effect first and the step SHALL start from zero membranes.
REQ-020 vmem SHALL persist across time steps (membrane carries over).
REQ-021 out_spikes SHALL hold its value until the next DONE.

Reset
REQ-022 wb_rst_i SHALL, at any point including mid-step, force IDLE; busy, done, w_rd_en, n_function_sel, n_weight and out_spikes are 0; all vmem entries, o and i are 0.
REQ-023 Reset SHALL clear the latched spikes, beta and v_th to 0.
REQ-024 No weight read SHALL be issued in the cycle after reset is released.

Structure
REQ-025 snn_pkg SHALL hold N_IN, N_OUT and W defaults and the FSM state enum.
REQ-026 The membrane store SHALL be one sub-module, snn_vmem_rf: N_OUT x W registers, one read port and one write port, synchronous clear.
REQ-027 The neuron SHALL be instantiated alongside neuron_sched by the parent, not inside it.

Verification
REQ-028 All in_spikes=0, beta=0, v_th=0x7F -> done exactly 136 cycles after busy rises; out_spikes=0; no w_rd_en.
REQ-029 in_spikes=0x0001, all weights 0x10, v_th=0x7F, beta=0 -> busy 144 cycles; w_addr sequence 0,16,32,...,112; vmem[o]=0x10 after first-step accumulation.
REQ-030 Same setup as REQ-029 with v_th=0x08 -> out_spikes=0xFF, and every vmem entry equals the neuron reset value.
REQ-031 start pulsed again at cycle 5 of a step -> single done pulse and unchanged latency; in_spikes toggled mid-step -> same result.
REQ-032 wb_rst_i asserted in cycle 20 of a step -> next cycle busy=0, w_rd_en=0, out_spikes=0; a following clean step behaves as from power-up.
REQ-033 clear_vmem with start in the same IDLE cycle after a step that left vmem[0]=0x10 -> accumulation restarts from 0.
